// File: rtl/divlut_pkg.sv
// Shared constants for the divide LUT and its loader: table geometry,
// reciprocal numerator exponent, saturation value and loader FSM encodings.
// Pure declarations; no logic, no latency, no flow control.
package divlut_pkg;

    localparam int LUT_NUMER_LOG2 = 20;
    localparam int LUT_DEPTH_LOG2 = 11;
    localparam int LUT_DATA_W     = 11;
    localparam int LUT_SAT        = (1 << LUT_DATA_W) - 1;

    // Loader FSM encodings, kept as plain constants so older LUT code can reuse them
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRIME  = 3'd1;
    localparam logic [2:0] ST_DIV    = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/div_restoring_seq.sv
// Unsigned iterative restoring divider, numerator NUM_W bits by divisor DEN_W bits.
// Latency: NUM_W cycles after start; done flags the final iteration, quotient valid next cycle.
// No backpressure: a new start restarts the divider unconditionally.
module div_restoring_seq #(
    parameter int NUM_W = 21,
    parameter int DEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] numer,
    input  logic [DEN_W-1:0] denom,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] num_sh;
    logic [DEN_W-1:0] den_q;
    logic [DEN_W:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             running;

    logic [DEN_W+1:0] rem_sh;
    logic [DEN_W+1:0] den_ext;
    logic             ge;
    logic [DEN_W:0]   diff;

    // Shift the next numerator bit into the partial remainder and trial-subtract
    always_comb begin
        rem_sh  = {rem, num_sh[NUM_W-1]};
        den_ext = {2'b00, den_q};
        ge      = (rem_sh >= den_ext);
        diff    = rem_sh[DEN_W:0] - den_ext[DEN_W:0];
    end

    // One quotient bit per cycle, MSB first; the remainder restores when the trial fails
    always_ff @(posedge clk) begin
        if (reset) begin
            num_sh   <= '0;
            den_q    <= '0;
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
            running  <= 1'b0;
        end else if (start) begin
            num_sh   <= numer;
            den_q    <= denom;
            rem      <= '0;
            quotient <= '0;
            cnt      <= CNT_W'(NUM_W);
            running  <= 1'b1;
        end else if (running) begin
            num_sh   <= {num_sh[NUM_W-2:0], 1'b0};
            rem      <= ge ? diff : rem_sh[DEN_W:0];
            quotient <= {quotient[NUM_W-2:0], ge};
            cnt      <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (cnt == CNT_W'(1));

endmodule

// File: rtl/divlut_loader.sv
// Builds the saturated 2^NUMER_LOG2/i reciprocal table and streams it into the divide LUT write port.
// Latency: 3 + (2^DEPTH_LOG2-1)*(NUMER_LOG2+2) cycles from start accept to done (45037 at defaults).
// No backpressure: the LUT accepts one write per strobe; start is ignored while a load is in flight.
module divlut_loader
    import divlut_pkg::*;
#(
    parameter int NUMER_LOG2 = LUT_NUMER_LOG2,
    parameter int DEPTH_LOG2 = LUT_DEPTH_LOG2,
    parameter int DATA_W     = LUT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              table_valid,
    output logic              lut_run,
    output logic [DATA_W-1:0] lut_wr_data,
    output logic              lut_wr_en
);

    localparam int                    Q_W        = NUMER_LOG2 + 1;
    localparam logic [DATA_W-1:0]     SAT        = '1;
    localparam logic [Q_W-1:0]        NUMER      = Q_W'(1) << NUMER_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = '1;

    logic [2:0]            state;
    logic [DEPTH_LOG2-1:0] index;

    logic                  div_start;
    logic                  div_done;
    logic [DATA_W-1:0]     div_den;
    logic [Q_W-1:0]        div_quo;
    logic [DATA_W-1:0]     entry;

    // The divisor for the next entry is latched while the current entry is being written,
    // so the divider runs for exactly the DIV dwell of the following entry.
    assign div_start = (state == ST_WRITE) && (index != LAST_INDEX);
    assign div_den   = DATA_W'(index) + DATA_W'(1);

    div_restoring_seq #(
        .NUM_W (Q_W),
        .DEN_W (DATA_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .numer    (NUMER),
        .denom    (div_den),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Entry value: divide-by-zero and oversize quotients both clamp to SAT
    always_comb begin
        entry = SAT;
        if (index != '0 && div_quo <= Q_W'(SAT)) begin
            entry = div_quo[DATA_W-1:0];
        end
    end

    // Load sequencer: prime the LUT address, then divide/write each entry in turn
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            index       <= '0;
            busy        <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_PRIME;
                        table_valid <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    index <= '0;
                    state <= ST_WRITE;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (index == LAST_INDEX) begin
                        state <= ST_FINISH;
                    end else begin
                        index <= index + 1'b1;
                        state <= ST_DIV;
                    end
                end
                ST_FINISH: begin
                    table_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // LUT-facing controls decode straight from state; run and write strobe are mutually exclusive
    always_comb begin
        lut_run     = 1'b0;
        lut_wr_en   = 1'b0;
        lut_wr_data = '0;
        done        = 1'b0;
        case (state)
            ST_IDLE:   lut_run = table_valid;
            ST_PRIME:  lut_run = 1'b1;
            ST_WRITE: begin
                lut_wr_en   = 1'b1;
                lut_wr_data = entry;
            end
            ST_FINISH: begin
                lut_run = 1'b1;
                done    = 1'b1;
            end
            default: begin
                lut_run = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_divlut_loader.sv
// Bench for divlut_loader with a behavioural divide LUT attached to its write port.
// Expected table entries are queued on each start and compared against captured writes.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_divlut_loader;

    localparam int NUM_ENTRIES = 2048;
    localparam int SAT         = 2047;
    localparam int NUMER       = 1 << 20;
    localparam int LOAD_CYCLES = 45037;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        table_valid;
    logic        lut_run;
    logic [10:0] lut_wr_data;
    logic        lut_wr_en;

    always #5 clk = ~clk;

    divlut_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .table_valid (table_valid),
        .lut_run     (lut_run),
        .lut_wr_data (lut_wr_data),
        .lut_wr_en   (lut_wr_en)
    );

    // Divide LUT model: run forces write address to 0 and enables registered reads
    logic [10:0] lut_mem [0:NUM_ENTRIES-1];
    logic [10:0] lut_wa = '0;
    logic [10:0] rd_addr = '0;
    logic [10:0] rd_data;

    always @(posedge clk) begin
        if (lut_run) begin
            lut_wa  <= '0;
            rd_data <= lut_mem[rd_addr];
        end else if (lut_wr_en) begin
            lut_mem[lut_wa] <= lut_wr_data;
            lut_wa          <= lut_wa + 11'd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor
    int act_q[$];
    int exp_q[$];
    int wr_cnt      = 0;
    int overlap_cnt = 0;
    int done_cnt    = 0;
    int done_cyc    = -1;

    always @(negedge clk) begin
        if (lut_wr_en) begin
            act_q.push_back(int'(lut_wr_data));
            wr_cnt <= wr_cnt + 1;
            if (lut_run) overlap_cnt <= overlap_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    int tbl1 [0:NUM_ENTRIES-1];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int model_entry(input int i);
        int q;
        if (i == 0) return SAT;
        q = NUMER / i;
        return (q > SAT) ? SAT : q;
    endfunction

    task automatic push_expected();
        exp_q.delete();
        act_q.delete();
        for (int i = 0; i < NUM_ENTRIES; i++) exp_q.push_back(model_entry(i));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL reset_table_valid: got %b want 0", table_valid); end
        checks++; if (lut_run !== 1'b0) begin errors++; $display("FAIL reset_lut_run: got %b want 0", lut_run); end
        checks++; if (lut_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", lut_wr_en); end
        checks++; if (lut_wr_data !== 11'd0) begin errors++; $display("FAIL reset_wr_data: got %0d want 0", lut_wr_data); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_abort_at_300();
        int base;
        int n;
        int bad;
        int k;
        push_expected();
        base = wr_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while ((wr_cnt - base) < 300 && k < 20000) begin
            step();
            k++;
        end
        checks++; if ((wr_cnt - base) < 300) begin errors++; $display("FAIL abort_reach_300: got %0d writes want 300", wr_cnt - base); end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (30) step();
        checks++; if ((wr_cnt - base) != 300) begin errors++; $display("FAIL abort_no_more_writes: got %0d writes want 300", wr_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL abort_table_valid: got %b want 0", table_valid); end
        checks++; if (lut_run !== 1'b0) begin errors++; $display("FAIL abort_lut_run: got %b want 0", lut_run); end
        checks++; if (lut_wr_en !== 1'b0 || lut_wr_data !== 11'd0) begin errors++; $display("FAIL abort_wr: got en=%b data=%0d want 0/0", lut_wr_en, lut_wr_data); end
        n = act_q.size();
        bad = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            int e;
            a = act_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (a != e) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_prefix_table: got %0d bad of %0d entries want 0", bad, n); end
        exp_q.delete();
    endtask

    task automatic test_full_load();
        int base;
        int ov_base;
        int dbase;
        int start_cyc;
        int k;
        int n;
        int bad;
        int first_bad;
        int spot_idx [6] = '{0, 1, 512, 513, 1000, 2047};
        int spot_val [6] = '{2047, 2047, 2047, 2044, 1048, 512};
        for (int i = 0; i < NUM_ENTRIES; i++) tbl1[i] = -1;
        push_expected();
        base    = wr_cnt;
        ov_base = overlap_cnt;
        dbase   = done_cnt;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        checks++; if (lut_run !== 1'b1) begin errors++; $display("FAIL prime_run: got %b want 1", lut_run); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        step();
        checks++; if (lut_run !== 1'b0) begin errors++; $display("FAIL run_after_prime: got %b want 0", lut_run); end
        checks++; if (lut_wr_en !== 1'b1 || lut_wr_data !== 11'd2047) begin errors++; $display("FAIL entry0_write: got en=%b data=%0d want 1/2047", lut_wr_en, lut_wr_data); end
        while (cyc < start_cyc + 100) step();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (done_cnt == dbase && k < LOAD_CYCLES + 1000) begin
            step();
            k++;
        end
        checks++; if (done_cnt == dbase) begin errors++; $display("FAIL done_timeout: got no done within %0d cycles want done", k); end
        checks++; if (done_cyc - start_cyc != LOAD_CYCLES) begin errors++; $display("FAIL done_latency: got %0d cycles want %0d", done_cyc - start_cyc, LOAD_CYCLES); end
        step();
        checks++; if (lut_run !== 1'b1) begin errors++; $display("FAIL run_after_load: got %b want 1", lut_run); end
        checks++; if (table_valid !== 1'b1) begin errors++; $display("FAIL table_valid_after_load: got %b want 1", table_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_load: got busy=%b done=%b want 0/0", busy, done); end
        repeat (5) step();
        checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL done_pulse_count: got %0d want 1", done_cnt - dbase); end
        checks++; if (wr_cnt - base != NUM_ENTRIES) begin errors++; $display("FAIL write_count: got %0d want %0d", wr_cnt - base, NUM_ENTRIES); end
        checks++; if (overlap_cnt != ov_base) begin errors++; $display("FAIL write_while_run: got %0d want 0", overlap_cnt - ov_base); end
        n = act_q.size();
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            int a;
            int e;
            a = act_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (i < NUM_ENTRIES) tbl1[i] = a;
            if (a != e) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++; if (bad != 0 || exp_q.size() != 0) begin errors++; $display("FAIL full_table: got %0d bad (first %0d), %0d unmatched want 0", bad, first_bad, exp_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tbl1[spot_idx[i]] != spot_val[i]) begin
                errors++;
                $display("FAIL entry_%0d: got %0d want %0d", spot_idx[i], tbl1[spot_idx[i]], spot_val[i]);
            end
        end
    endtask

    task automatic test_lut_read();
        int rd_a [3] = '{513, 2047, 0};
        int rd_w [3] = '{2044, 512, 2047};
        for (int i = 0; i < 3; i++) begin
            rd_addr = 11'(rd_a[i]);
            step();
            checks++;
            if (lut_run !== 1'b1 || rd_data !== 11'(rd_w[i])) begin
                errors++;
                $display("FAIL lut_read_%0d: got %0d (run=%b) want %0d", rd_a[i], rd_data, lut_run, rd_w[i]);
            end
        end
    endtask

    task automatic test_restart();
        int base;
        int k;
        int n;
        int bad;
        checks++; if (table_valid !== 1'b1) begin errors++; $display("FAIL restart_pre_valid: got %b want 1", table_valid); end
        push_expected();
        base = wr_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL restart_valid_drop: got %b want 0", table_valid); end
        checks++; if (lut_run !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL restart_prime: got run=%b busy=%b want 1/1", lut_run, busy); end
        step();
        checks++; if (lut_run !== 1'b0) begin errors++; $display("FAIL restart_run_low: got %b want 0", lut_run); end
        k = 0;
        while ((wr_cnt - base) < 64 && k < 5000) begin
            step();
            k++;
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        n = act_q.size();
        checks++; if (n < 64) begin errors++; $display("FAIL restart_write_count: got %0d want >=64", n); end
        bad = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            int e;
            a = act_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (a != e || a != tbl1[i]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL restart_table_identical: got %0d bad of %0d want 0", bad, n); end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_abort_at_300();
        test_full_load();
        test_lut_read();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
